// File: rtl/min_sec_counter_if.sv
// Bundle of control inputs and display/pulse outputs for the minutes:seconds counter.
// The master side drives the controls; the slave side is the counter itself.
interface min_sec_counter_if;
  logic       run;
  logic       adj_min;
  logic       adj_hr;
  logic       clr_sec;
  logic [3:0] SH;
  logic [3:0] SL;
  logic [3:0] MH;
  logic [3:0] ML;
  logic       hour_en;
  logic       hour_adj;
  logic       sec_tick;

  modport master (
    output run, adj_min, adj_hr, clr_sec,
    input  SH, SL, MH, ML, hour_en, hour_adj, sec_tick
  );

  modport slave (
    input  run, adj_min, adj_hr, clr_sec,
    output SH, SL, MH, ML, hour_en, hour_adj, sec_tick
  );
endinterface

// File: rtl/min_sec_counter.sv
// BCD minutes:seconds counter with a clk-cycle prescaler, button adjust edges
// and one-cycle carry/adjust pulses for a downstream hours counter.
module min_sec_counter #(
  parameter int DIV = 50000000
) (
  input logic              clk,
  input logic              rst,
  min_sec_counter_if.slave bus
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] presc;
  logic          adj_min_q;
  logic          adj_hr_q;

  logic       tick;
  logic       min_edge;
  logic       hr_edge;
  logic       sec_wrap;
  logic       min_at_59;
  logic [3:0] sh_n;
  logic [3:0] sl_n;
  logic [3:0] mh_n;
  logic [3:0] ml_n;

  // clr_sec masks the tick so a held clear can never leak a carry downstream
  always_comb begin
    tick      = bus.run && !bus.clr_sec && (presc == LAST);
    min_edge  = bus.adj_min && !adj_min_q;
    hr_edge   = bus.adj_hr && !adj_hr_q;
    sec_wrap  = tick && (bus.SH == 4'd5) && (bus.SL == 4'd9);
    min_at_59 = (bus.MH == 4'd5) && (bus.ML == 4'd9);

    sh_n = bus.SH;
    sl_n = bus.SL + 4'd1;
    if (bus.SL == 4'd9) begin
      sl_n = 4'd0;
      sh_n = (bus.SH == 4'd5) ? 4'd0 : bus.SH + 4'd1;
    end

    mh_n = bus.MH;
    ml_n = bus.ML + 4'd1;
    if (bus.ML == 4'd9) begin
      ml_n = 4'd0;
      mh_n = (bus.MH == 4'd5) ? 4'd0 : bus.MH + 4'd1;
    end
  end

  // A manual minute step on the carry edge absorbs the carry: one increment, no hour_en
  always_ff @(posedge clk) begin
    if (rst) begin
      presc        <= '0;
      bus.SH       <= 4'd0;
      bus.SL       <= 4'd0;
      bus.MH       <= 4'd0;
      bus.ML       <= 4'd0;
      bus.hour_en  <= 1'b0;
      bus.hour_adj <= 1'b0;
      bus.sec_tick <= 1'b0;
      adj_min_q    <= bus.adj_min;
      adj_hr_q     <= bus.adj_hr;
    end else begin
      adj_min_q    <= bus.adj_min;
      adj_hr_q     <= bus.adj_hr;
      bus.sec_tick <= tick;
      bus.hour_adj <= hr_edge;
      bus.hour_en  <= sec_wrap && min_at_59 && !min_edge;

      if (bus.clr_sec) begin
        presc  <= '0;
        bus.SH <= 4'd0;
        bus.SL <= 4'd0;
      end else if (bus.run) begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) begin
          bus.SH <= sh_n;
          bus.SL <= sl_n;
        end
      end

      if (min_edge || sec_wrap) begin
        bus.MH <= mh_n;
        bus.ML <= ml_n;
      end
    end
  end

endmodule

// File: doc/min_sec_counter.md
MIN_SEC_COUNTER -- requirements
Module: min_sec_counter

Interface
REQ-001 SHALL have parameter DIV, default 50000000, the number of clk cycles per second (legal range 2..2^26).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port run  input  1  count enable; 1 = time advances, 0 = prescaler and time hold.
REQ-005 SHALL have port adj_min  input  1  minute-adjust level (debounced button); acts on its rising edge only.
REQ-006 SHALL have port adj_hr  input  1  hour-adjust level (debounced button); acts on its rising edge only.
REQ-007 SHALL have port clr_sec  input  1  level; clears seconds and prescaler while high.
REQ-008 SHALL have ports SH, SL  output  4 each  registered BCD tens/units of seconds.
REQ-009 SHALL have ports MH, ML  output  4 each  registered BCD tens/units of minutes.
REQ-010 SHALL have port hour_en  output  1  registered one-cycle carry pulse to the downstream hours counter.
REQ-011 SHALL have port hour_adj  output  1  registered one-cycle hour-adjust pulse to the downstream hours counter.
REQ-012 SHALL have port sec_tick  output  1  registered one-cycle pulse per elapsed second.

Function
REQ-013 SHALL hold a prescaler counting 0..DIV-1 while run=1 and rst=0, and hold it while run=0.
REQ-014 SHALL, on the edge where prescaler=DIV-1 and run=1, load prescaler with 0, advance seconds by one, and drive sec_tick=1 for that following cycle only.
REQ-015 SHALL count seconds in BCD 00..59: SL 0..9, then SL=0 with SH+1; at 59 wrap to 00 and generate a minute carry on the same edge.
REQ-016 SHALL count minutes in BCD 00..59 on a minute carry, with the same digit rules; 59 wraps to 00.
REQ-017 SHALL, on the edge where time wraps 59:59 -> 00:00 from a seconds advance, drive hour_en=1 for exactly one cycle.
REQ-018 SHALL detect adj_min rising edges via a registered copy of adj_min; each edge increments minutes by one mod 60, independent of run, without touching seconds or prescaler.
REQ-019 SHALL never assert hour_en due to adj_min, including a 59 -> 00 minute wrap.
REQ-020 SHALL, when an adj_min edge and a minute carry coincide, increment minutes by exactly one (carry absorbed), wrap seconds normally, and suppress hour_en.
REQ-021 SHALL detect adj_hr rising edges via a registered copy of adj_hr and drive hour_adj=1 for one cycle per edge, independent of run.
REQ-022 SHALL, while clr_sec=1, load seconds with 00 and prescaler with 0 every cycle, producing no sec_tick, minute carry or hour_en; clr_sec takes priority over the tick.
REQ-023 SHALL never present a non-BCD digit or a value above 59 on SH:SL or MH:ML.
REQ-024 SHALL keep hour_en, hour_adj and sec_tick low in every cycle not explicitly defined above.

Reset
REQ-025 SHALL, on any edge with rst=1, load SH, SL, MH, ML, prescaler, hour_en, hour_adj, sec_tick with 0 and the adj_min/adj_hr edge-detect registers with the current input levels, overriding all other inputs.
REQ-026 SHALL, when rst asserts mid-count, abandon the partial second; counting restarts from prescaler 0 on the first edge with rst=0.

Verification
REQ-027 SHALL pass: DIV=4, reset released, run=1 for 8 cycles -> sec_tick pulses at cycles 4 and 8, SL=1 then 2, hour_en stays 0.
REQ-028 SHALL pass: DIV=2, time preset via run to 59:58, run=1 -> 59:59 then 00:00 with hour_en=1 for exactly one cycle at that edge.
REQ-029 SHALL pass: run=0 at 12:34, adj_min held high 5 cycles then low -> minutes 13 exactly once, SH:SL unchanged, hour_en=0.
REQ-030 SHALL pass: time 59:59, adj_min rising edge on the same edge as the tick -> 00:00, hour_en=0.
REQ-031 SHALL pass: clr_sec held 3 cycles at 07:45 with run=1 -> SH:SL=00, MH:ML=07, no sec_tick; then adj_hr rising edge -> hour_adj=1 for one cycle.
REQ-032 SHALL pass: rst=1 for one cycle at 33:21 mid-second -> all outputs 0 on the next cycle, first sec_tick exactly DIV cycles after rst deasserts.
